// File: rtl/xcvr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xcvr_pkg
// Brief   : Shared types and constants for the transceiver direction control.
// Revision: 1.0
// ============================================================================
package xcvr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic DIR_TX = 1'b1;
  localparam logic DIR_RX = 1'b0;

  // A dead period is needed when no direction has ever been driven or it reverses.
  function automatic logic dir_change(input logic valid, input logic cur, input logic nxt);
    return !valid || (cur != nxt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xcvr_dir_ctrl_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module  : arb_rr2
// Brief   : Two-way round-robin arbiter; pointer flips only on a contested grant.
// Revision: 1.0
// ============================================================================
module arb_rr2
  import xcvr_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic tx_req,
  input  logic rx_req,
  input  logic take,
  output logic gnt_valid,
  output logic gnt_tx
);

  logic r_ptr_tx;

  always_comb begin
    gnt_valid = tx_req | rx_req;
    gnt_tx    = (tx_req && rx_req) ? r_ptr_tx : tx_req;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr_tx <= DIR_TX;
    end else if (take && tx_req && rx_req) begin
      r_ptr_tx <= ~r_ptr_tx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xcvr_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : xcvr_dir_ctrl
// Brief   : Break-before-make direction sequencer for an octal bus transceiver.
// Revision: 1.0
// ============================================================================
module xcvr_dir_ctrl
  import xcvr_pkg::*;
#(
  parameter int TURN_CYC = 1,
  parameter int XFER_CYC = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tx_req,
  input  logic rx_req,
  output logic tx_ack,
  output logic rx_ack,
  output logic T_n,
  output logic R_n,
  output logic busy,
  output logic dir
);

  localparam int c_max_cyc = (TURN_CYC > XFER_CYC) ? TURN_CYC : XFER_CYC;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);
  localparam logic [c_cnt_w-1:0] c_turn_ld = (TURN_CYC > 0) ? c_cnt_w'(TURN_CYC - 1) : '0;
  localparam logic [c_cnt_w-1:0] c_xfer_ld = c_cnt_w'(XFER_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
  localparam logic               c_one_shot = (XFER_CYC == 1);

  generate
    if (XFER_CYC < 1) begin : g_bad_xfer_cyc
      $error("xcvr_dir_ctrl: XFER_CYC must be >= 1");
    end
  endgenerate

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_dir_valid;
  logic                 r_gnt_tx;
  logic                 w_gnt_valid;
  logic                 w_gnt_tx;
  logic                 w_take;
  logic                 w_need_turn;

  assign w_take      = (r_state == IDLE) && w_gnt_valid;
  assign w_need_turn = (TURN_CYC > 0) && dir_change(r_dir_valid, dir, w_gnt_tx);

  arb_rr2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_req    (tx_req),
    .rx_req    (rx_req),
    .take      (w_take),
    .gnt_valid (w_gnt_valid),
    .gnt_tx    (w_gnt_tx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dir_valid <= 1'b0;
      r_gnt_tx    <= DIR_TX;
      T_n         <= 1'b1;
      R_n         <= 1'b1;
      tx_ack      <= 1'b0;
      rx_ack      <= 1'b0;
      busy        <= 1'b0;
      dir         <= DIR_TX;
    end else begin
      tx_ack <= 1'b0;
      rx_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_tx <= w_gnt_tx;
            busy     <= 1'b1;
            if (w_need_turn) begin
              r_state <= TURN;
              r_cnt   <= c_turn_ld;
            end else begin
              r_state     <= XFER;
              r_cnt       <= c_xfer_ld;
              r_dir_valid <= 1'b1;
              dir         <= w_gnt_tx;
              T_n         <= ~w_gnt_tx;
              R_n         <= w_gnt_tx;
              tx_ack      <= c_one_shot & w_gnt_tx;
              rx_ack      <= c_one_shot & ~w_gnt_tx;
            end
          end
        end
        TURN: begin
          if (r_cnt == '0) begin
            r_state     <= XFER;
            r_cnt       <= c_xfer_ld;
            r_dir_valid <= 1'b1;
            dir         <= r_gnt_tx;
            T_n         <= ~r_gnt_tx;
            R_n         <= r_gnt_tx;
            tx_ack      <= c_one_shot & r_gnt_tx;
            rx_ack      <= c_one_shot & ~r_gnt_tx;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        XFER: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            T_n     <= 1'b1;
            R_n     <= 1'b1;
            busy    <= 1'b0;
          end else begin
            // Ack lands in the cycle where the counter will read zero.
            r_cnt  <= r_cnt - c_one;
            tx_ack <= (r_cnt == c_one) & r_gnt_tx;
            rx_ack <= (r_cnt == c_one) & ~r_gnt_tx;
          end
        end
        default: begin
          r_state <= IDLE;
          T_n     <= 1'b1;
          R_n     <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
